knn_list_reader: RTL and testbench

- Read-side counterpart of the K-entry sorted neighbour list in the KNN accelerator.
- On a start request it snapshots the flattened list, entry 0 being the nearest neighbour. It then streams the occupied entries out one per valid/ready beat, in ascending-distance order.
- Empty slots still hold their reset value (distance field all ones). Streaming stops at the first empty slot, and a done pulse reports the occupied-entry count.
- Sits between the list chain and the label-vote / CPU readout logic.

---
 rtl/knn_pkg.sv | 18 +
 rtl/knn_list_reader.sv | 117 +++++++++++
 tb/tb_knn_list_reader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/knn_pkg.sv
// Shared constants and state encoding for the KNN neighbour-list blocks.
// EMPTY_DIST is also the reset value of a list element's distance field.
package knn_pkg;

  localparam int KNN_DATA_W = 32;
  localparam int KNN_LABEL  = 8;
  localparam int KNN_K      = 10;
  localparam int ENTRY_W    = KNN_DATA_W + KNN_LABEL;

  localparam logic [KNN_DATA_W-1:0] EMPTY_DIST = '1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

endpackage

// File: rtl/knn_list_reader.sv
// Snapshots the sorted K-entry neighbour list and streams the occupied
// entries nearest-first over valid/ready, then pulses done with the count.
module knn_list_reader
  import knn_pkg::*;
#(
  parameter int DATA_W = KNN_DATA_W,
  parameter int LABEL  = KNN_LABEL,
  parameter int K      = KNN_K
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [K*(DATA_W+LABEL)-1:0] list_in,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_dist,
  output logic [LABEL-1:0]           out_label,
  output logic [$clog2(K)-1:0]       out_idx,
  output logic                       out_last,
  output logic                       done,
  output logic [$clog2(K+1)-1:0]     n_valid
);

  localparam int EW = DATA_W + LABEL;
  localparam int IW = $clog2(K);
  localparam int CW = $clog2(K+1);
  localparam logic [DATA_W-1:0] EMPTY   = {DATA_W{1'b1}};
  localparam logic [IW-1:0]     IDX_ONE = IW'(1);
  localparam logic [CW-1:0]     CNT_ONE = CW'(1);

  state_t state, next_state;

  logic [DATA_W-1:0] in_dist   [K];
  logic [LABEL-1:0]  in_label  [K];
  logic [DATA_W-1:0] snap_dist [K];
  logic [LABEL-1:0]  snap_label[K];
  logic [K-1:0]      next_empty;
  logic [IW-1:0]     idx;
  logic [CW-1:0]     cnt;
  logic              last;
  logic              accept_start;
  logic              beat_fire;

  // Each entry is {dist, label}; next_empty[i] marks entry i as the tail.
  for (genvar i = 0; i < K; i++) begin : g_entry
    assign in_dist[i]  = list_in[i*EW+LABEL +: DATA_W];
    assign in_label[i] = list_in[i*EW +: LABEL];
    if (i == K-1) begin : g_tail
      assign next_empty[i] = 1'b1;
    end else begin : g_mid
      assign next_empty[i] = (snap_dist[i+1] == EMPTY);
    end
  end

  assign accept_start = (state == IDLE) && start;
  assign last         = next_empty[idx];
  assign beat_fire    = (state == STREAM) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (in_dist[0] == EMPTY) ? DONE : STREAM;
      STREAM:  if (out_ready && last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The beat counter doubles as n_valid, so it is only cleared by a new start.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      cnt <= '0;
      for (int i = 0; i < K; i++) begin
        snap_dist[i]  <= EMPTY;
        snap_label[i] <= '1;
      end
    end else if (accept_start) begin
      idx <= '0;
      cnt <= '0;
      for (int i = 0; i < K; i++) begin
        snap_dist[i]  <= in_dist[i];
        snap_label[i] <= in_label[i];
      end
    end else if (beat_fire) begin
      cnt <= cnt + CNT_ONE;
      if (!last) idx <= idx + IDX_ONE;
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    out_valid = (state == STREAM);
    done      = (state == DONE);
    out_dist  = '0;
    out_label = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    n_valid   = cnt;
    if (state == STREAM) begin
      out_dist  = snap_dist[idx];
      out_label = snap_label[idx];
      out_idx   = idx;
      out_last  = last;
    end
  end

endmodule

// File: tb/tb_knn_list_reader.sv
// Directed and randomized checks of knn_list_reader against a queue-based
// model of the list's occupied prefix.
module tb_knn_list_reader;
  import knn_pkg::*;

  localparam int DW = 32;
  localparam int LW = 8;
  localparam int K  = 4;
  localparam int EW = DW + LW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [K*EW-1:0]   list_in = '1;
  logic              busy;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     out_dist;
  logic [LW-1:0]     out_label;
  logic [1:0]        out_idx;
  logic              out_last;
  logic              done;
  logic [2:0]        n_valid;

  logic [DW-1:0]     dist_tab [K];
  logic [LW-1:0]     label_tab[K];

  int passed = 0;
  int total  = 0;

  knn_list_reader #(.DATA_W(DW), .LABEL(LW), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .list_in(list_in), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_dist(out_dist),
    .out_label(out_label), .out_idx(out_idx), .out_last(out_last),
    .done(done), .n_valid(n_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [K*EW-1:0] packList();
    logic [K*EW-1:0] v;
    for (int i = 0; i < K; i++) v[i*EW +: EW] = {dist_tab[i], label_tab[i]};
    return v;
  endfunction

  task automatic setList(input logic [DW-1:0] d0, d1, d2, d3,
                         input logic [LW-1:0] l0, l1, l2, l3);
    dist_tab[0] = d0; dist_tab[1] = d1; dist_tab[2] = d2; dist_tab[3] = d3;
    label_tab[0] = l0; label_tab[1] = l1; label_tab[2] = l2; label_tab[3] = l3;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic applyStimulus(input int ready_mode, input bit disturb);
    logic [DW-1:0] qd[$];
    logic [LW-1:0] ql[$];
    int  n, beat;
    bit  seen_done, disturbed;
    for (int i = 0; i < K; i++) begin
      if (dist_tab[i] == EMPTY_DIST) break;
      qd.push_back(dist_tab[i]);
      ql.push_back(label_tab[i]);
    end
    n = qd.size();
    list_in = packList();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (n > 0) checkOutput("latency_valid", out_valid, 1);
    else       checkOutput("latency_done", done, 1);
    beat = 0;
    seen_done = 0;
    disturbed = 0;
    for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
      start = 1'b0;
      if (done) begin
        checkOutput("n_valid", n_valid, n);
        checkOutput("beat_count", beat, n);
        checkOutput("done_valid_low", out_valid, 0);
        seen_done = 1;
        start = 1'b1;
      end else begin
        checkOutput("busy_high", busy, 1);
        if (out_valid) begin
          if (beat < n) begin
            checkOutput("dist", out_dist, qd[beat]);
            checkOutput("label", out_label, ql[beat]);
            checkOutput("idx", out_idx, beat);
            checkOutput("last", out_last, beat == n-1);
          end else begin
            checkOutput("extra_beat", beat, n);
          end
        end
        case (ready_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = (cyc % 3 == 0);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (out_valid && out_ready) beat++;
        if (disturb && !disturbed && beat == 1) begin
          disturbed = 1;
          start = 1'b1;
          list_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
        end
      end
      @(negedge clk);
    end
    if (!seen_done) checkOutput("timeout_done", 0, 1);
    start = 1'b0;
    out_ready = 1'b0;
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_done", done, 0);
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_n_valid", n_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] full list");
    setList(5, 9, 12, 20, 8'h01, 8'h02, 8'h03, 8'h04);
    applyStimulus(0, 0);

    $display("[TB] partial list");
    setList(7, 30, EMPTY_DIST, EMPTY_DIST, 8'h0A, 8'h0B, 8'h00, 8'h00);
    applyStimulus(0, 0);

    $display("[TB] empty list");
    setList(EMPTY_DIST, EMPTY_DIST, EMPTY_DIST, EMPTY_DIST, 8'h11, 8'h22, 8'h33, 8'h44);
    applyStimulus(0, 0);

    $display("[TB] stalled full list");
    setList(5, 9, 12, 20, 8'h01, 8'h02, 8'h03, 8'h04);
    applyStimulus(1, 0);

    $display("[TB] mid-stream start and list change, then immediate restart");
    applyStimulus(0, 1);
    setList(7, 30, EMPTY_DIST, EMPTY_DIST, 8'h0A, 8'h0B, 8'h00, 8'h00);
    applyStimulus(0, 0);

    $display("[TB] reset mid-stream");
    setList(5, 9, 12, 20, 8'h01, 8'h02, 8'h03, 8'h04);
    list_in = packList();
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_idx", out_idx, 1);
    checkOutput("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_valid", out_valid, 0);
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_done2", done, 0);
    checkOutput("post_rst_valid2", out_valid, 0);
    applyStimulus(0, 0);

    $display("[TB] randomized lists");
    for (int t = 0; t < 25; t++) begin
      int occ;
      logic [DW-1:0] d;
      occ = $urandom_range(0, K);
      d = '0;
      for (int i = 0; i < K; i++) begin
        if (i < occ) begin
          d = d + DW'($urandom_range(1, 1000));
          dist_tab[i] = d;
        end else begin
          dist_tab[i] = EMPTY_DIST;
        end
        label_tab[i] = LW'($urandom);
      end
      applyStimulus($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
